// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between the
// pipeline WB stage and a FIFO of long-latency results, with an age-based forced drain.
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       pipe_wen,
    input  logic [4:0]                 pipe_wsel,
    input  logic [31:0]                pipe_wdat,
    output logic                       pipe_stall,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic [4:0]                 ext_wsel,
    input  logic [31:0]                ext_wdat,
    output logic                       rf_wen,
    output logic [4:0]                 rf_wsel,
    output logic [31:0]                rf_wdat,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] AGE_LIMIT = AW'(STARVE_MAX - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  count;
    logic [AW-1:0]  age;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [4:0]     mem_wsel [DEPTH];
    logic [31:0]    mem_wdat [DEPTH];

    logic pipe_req, head_valid;
    logic grant_pipe, grant_head;
    logic enq, deq;

    assign pipe_req   = pipe_wen && (pipe_wsel != 5'd0);
    assign head_valid = (count != '0);

    always_comb begin
        state_next = NORMAL;
        grant_pipe = 1'b0;
        grant_head = 1'b0;
        pipe_stall = 1'b0;
        if (nRST) begin
            unique case (state)
                NORMAL: begin
                    if (pipe_req)
                        grant_pipe = 1'b1;
                    else if (head_valid)
                        grant_head = 1'b1;
                    if (head_valid && !grant_head && age == AGE_LIMIT)
                        state_next = FORCE;
                end
                FORCE: begin
                    grant_head = head_valid;
                    pipe_stall = pipe_req;
                    state_next = NORMAL;
                end
                default: state_next = NORMAL;
            endcase
        end
    end

    always_comb begin
        rf_wen  = 1'b0;
        rf_wsel = 5'd0;
        rf_wdat = 32'd0;
        if (grant_pipe) begin
            rf_wen  = 1'b1;
            rf_wsel = pipe_wsel;
            rf_wdat = pipe_wdat;
        end else if (grant_head) begin
            rf_wen  = 1'b1;
            rf_wsel = mem_wsel[rd_ptr];
            rf_wdat = mem_wdat[rd_ptr];
        end
    end

    // Ready looks only at the registered count, so a full FIFO refuses even while draining.
    assign ext_ready  = nRST && (count < FULL);
    assign enq        = ext_valid && ext_ready && (ext_wsel != 5'd0);
    assign deq        = grant_head;
    assign fifo_count = count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= NORMAL;
            count  <= '0;
            age    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            if (enq && !deq)
                count <= count + CW'(1);
            else if (deq && !enq)
                count <= count - CW'(1);
            if (!head_valid || grant_head)
                age <= '0;
            else if (age != AGE_LIMIT)
                age <= age + AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_wsel[wr_ptr] <= ext_wsel;
            mem_wdat[wr_ptr] <= ext_wdat;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs driven on the falling edge,
// combinational outputs checked 1ns later, ahead of the next rising edge.
module tb_wb_port_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        pipe_wen;
    logic [4:0]  pipe_wsel;
    logic [31:0] pipe_wdat;
    logic        pipe_stall;
    logic        ext_valid;
    logic        ext_ready;
    logic [4:0]  ext_wsel;
    logic [31:0] ext_wdat;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_port_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
        .pipe_stall(pipe_stall),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_wsel(ext_wsel), .ext_wdat(ext_wdat),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // Advance to the next falling edge and apply a full input vector.
    task automatic drive(input logic rst_n, input logic pw, input logic [4:0] ps,
                         input logic [31:0] pd, input logic ev, input logic [4:0] es,
                         input logic [31:0] ed);
        @(negedge CLK);
        nRST = rst_n; pipe_wen = pw; pipe_wsel = ps; pipe_wdat = pd;
        ext_valid = ev; ext_wsel = es; ext_wdat = ed;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'd5);
        n_cmp++;
        if (rf_wen !== 1'b0 || ext_ready !== 1'b0 || pipe_stall !== 1'b0 ||
            rf_wsel !== 5'd0 || rf_wdat !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: rf_wen=%b ext_ready=%b stall=%b wsel=%0d wdat=%h want 0 0 0 0 0",
                     rf_wen, ext_ready, pipe_stall, rf_wsel, rf_wdat);
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (ext_ready !== 1'b1 || fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b count=%0d rf_wen=%b want 1 0 0",
                     ext_ready, fifo_count, rf_wen);
        end
    endtask

    task automatic test_pipe_only();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (rf_wen !== 1'b1 || rf_wsel !== 5'd5 || rf_wdat !== 32'hDEADBEEF || pipe_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL pipe_only: wen=%b wsel=%0d wdat=%h stall=%b want 1 5 deadbeef 0",
                     rf_wen, rf_wsel, rf_wdat, pipe_stall);
        end
    endtask

    task automatic test_ext_idle();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        n_cmp++;
        if (ext_ready !== 1'b1 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_accept_cycle: ready=%b rf_wen=%b want 1 0 (no bypass)", ext_ready, rf_wen);
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (rf_wen !== 1'b1 || rf_wsel !== 5'd7 || rf_wdat !== 32'h11 || fifo_count !== 3'd1) begin
            n_bad++;
            $display("FAIL ext_write: wen=%b wsel=%0d wdat=%h count=%0d want 1 7 11 1",
                     rf_wen, rf_wsel, rf_wdat, fifo_count);
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_drained: count=%0d rf_wen=%b want 0 0", fifo_count, rf_wen);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd2, 32'hA0 + i, 1'b1, 5'(10 + i), 32'hB0 + i);
            n_cmp++;
            if (ext_ready !== 1'b1 || rf_wsel !== 5'd2 || fifo_count !== 3'(i)) begin
                n_bad++;
                $display("FAIL fill_%0d: ready=%b rf_wsel=%0d count=%0d want 1 2 %0d",
                         i, ext_ready, rf_wsel, fifo_count, i);
            end
        end
        drive(1'b1, 1'b1, 5'd2, 32'hAF, 1'b1, 5'd14, 32'hBF);
        n_cmp++;
        if (ext_ready !== 1'b0 || fifo_count !== 3'd4 || pipe_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL full: ready=%b count=%0d stall=%b want 0 4 0", ext_ready, fifo_count, pipe_stall);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_cmp++;
            if (rf_wen !== 1'b1 || rf_wsel !== 5'(10 + i) || rf_wdat !== 32'hB0 + i ||
                fifo_count !== 3'(4 - i)) begin
                n_bad++;
                $display("FAIL drain_%0d: wen=%b wsel=%0d wdat=%h count=%0d want 1 %0d %h %0d",
                         i, rf_wen, rf_wsel, rf_wdat, fifo_count, 10 + i, 32'hB0 + i, 4 - i);
            end
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL no_fifth: count=%0d rf_wen=%b want 0 0", fifo_count, rf_wen);
        end
    endtask

    task automatic test_starvation();
        drive(1'b1, 1'b1, 5'd4, 32'h50, 1'b1, 5'd9, 32'h99);
        n_cmp++;
        if (rf_wsel !== 5'd4 || rf_wdat !== 32'h50) begin
            n_bad++;
            $display("FAIL starve_start: wsel=%0d wdat=%h want 4 50", rf_wsel, rf_wdat);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 5'd4, 32'(100 + k), 1'b0, 5'd0, 32'd0);
            n_cmp++;
            if (rf_wen !== 1'b1 || rf_wsel !== 5'd4 || rf_wdat !== 32'(100 + k) ||
                pipe_stall !== 1'b0 || fifo_count !== 3'd1) begin
                n_bad++;
                $display("FAIL starve_wait_%0d: wen=%b wsel=%0d wdat=%0d stall=%b count=%0d want 1 4 %0d 0 1",
                         k, rf_wen, rf_wsel, rf_wdat, pipe_stall, fifo_count, 100 + k);
            end
        end
        drive(1'b1, 1'b1, 5'd4, 32'd200, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (pipe_stall !== 1'b1 || rf_wen !== 1'b1 || rf_wsel !== 5'd9 || rf_wdat !== 32'h99) begin
            n_bad++;
            $display("FAIL force: stall=%b wen=%b wsel=%0d wdat=%h want 1 1 9 99",
                     pipe_stall, rf_wen, rf_wsel, rf_wdat);
        end
        drive(1'b1, 1'b1, 5'd4, 32'd200, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (pipe_stall !== 1'b0 || rf_wsel !== 5'd4 || rf_wdat !== 32'd200 || fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL force_resume: stall=%b wsel=%0d wdat=%0d count=%0d want 0 4 200 0",
                     pipe_stall, rf_wsel, rf_wdat, fifo_count);
        end
    endtask

    task automatic test_wsel_zero();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_wsel0: count=%0d rf_wen=%b want 0 0", fifo_count, rf_wen);
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (rf_wen !== 1'b1 || rf_wsel !== 5'd6 || rf_wdat !== 32'h66 || pipe_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL pipe_wsel0: wen=%b wsel=%0d wdat=%h stall=%b want 1 6 66 0",
                     rf_wen, rf_wsel, rf_wdat, pipe_stall);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, (i < 2), 5'(21 + i), 32'(33 + i));
            n_cmp++;
            if (rf_wen !== 1'b1 || rf_wsel !== 5'(20 + i) || fifo_count !== 3'd1) begin
                n_bad++;
                $display("FAIL b2b_%0d: wen=%b wsel=%0d count=%0d want 1 %0d 1",
                         i, rf_wen, rf_wsel, fifo_count, 20 + i);
            end
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: count=%0d rf_wen=%b want 0 0", fifo_count, rf_wen);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 5'd2, 32'd0, 1'b1, 5'(24 + i), 32'(i));
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++;
        if (fifo_count !== 3'd3 || rf_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_drain_pre: count=%0d rf_wen=%b want 3 0", fifo_count, rf_wen);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_cmp++;
            if (fifo_count !== 3'd0 || rf_wen !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_drain_post_%0d: count=%0d rf_wen=%b want 0 0", i, fifo_count, rf_wen);
            end
        end
    endtask

    initial begin
        nRST = 1'b0; pipe_wen = 1'b0; pipe_wsel = '0; pipe_wdat = '0;
        ext_valid = 1'b0; ext_wsel = '0; ext_wdat = '0;
        test_reset();
        test_pipe_only();
        test_ext_idle();
        test_full();
        test_starvation();
        test_wsel_zero();
        test_back_to_back();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
